// File: rtl/alsu_cmd_issuer_pkg.sv
// Shared types for the ALSU command issuer: opcodes, command/pin structs, idle command
// and the validity check used when ALSU_CMD_FILTER_EN is defined.
package alsu_cmd_issuer_pkg;

  localparam int CMD_RPT_W = 3;

  typedef enum logic [2:0] {
    OR        = 3'd0,
    XOR       = 3'd1,
    ADD       = 3'd2,
    MULT      = 3'd3,
    SHIFT     = 3'd4,
    ROTATE    = 3'd5,
    INVALID_1 = 3'd6,
    INVALID_2 = 3'd7
  } opcode_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    REPEAT = 2'd2
  } issuer_state_e;

  typedef struct packed {
    opcode_e               opcode;
    logic signed [2:0]     A;
    logic signed [2:0]     B;
    logic                  cin;
    logic                  serial_in;
    logic                  red_op_A;
    logic                  red_op_B;
    logic                  bypass_A;
    logic                  bypass_B;
    logic                  direction;
    logic [CMD_RPT_W-1:0]  rpt;
  } alsu_cmd_t;

  // Pin image driven to the ALSU; the repeat count never leaves the issuer.
  typedef struct packed {
    opcode_e           opcode;
    logic signed [2:0] A;
    logic signed [2:0] B;
    logic              cin;
    logic              serial_in;
    logic              red_op_A;
    logic              red_op_B;
    logic              bypass_A;
    logic              bypass_B;
    logic              direction;
  } alsu_pins_t;

  localparam alsu_cmd_t IDLE_CMD = '{opcode: OR, A: 3'sd0, B: 3'sd0, cin: 1'b0,
                                     serial_in: 1'b0, red_op_A: 1'b0, red_op_B: 1'b0,
                                     bypass_A: 1'b0, bypass_B: 1'b0, direction: 1'b0,
                                     rpt: '0};

  function automatic logic is_invalid_cmd(input alsu_cmd_t c);
    logic bad_op;
    logic bad_red;
    bad_op  = (c.opcode == INVALID_1) || (c.opcode == INVALID_2);
    bad_red = (c.red_op_A || c.red_op_B) && !((c.opcode == OR) || (c.opcode == XOR));
    return bad_op || bad_red;
  endfunction

  function automatic logic is_repeat_op(input opcode_e op);
    return (op == SHIFT) || (op == ROTATE);
  endfunction

  function automatic alsu_pins_t to_pins(input alsu_cmd_t c);
    alsu_pins_t p;
    p.opcode    = c.opcode;
    p.A         = c.A;
    p.B         = c.B;
    p.cin       = c.cin;
    p.serial_in = c.serial_in;
    p.red_op_A  = c.red_op_A;
    p.red_op_B  = c.red_op_B;
    p.bypass_A  = c.bypass_A;
    p.bypass_B  = c.bypass_B;
    p.direction = c.direction;
    return p;
  endfunction

endpackage

// File: rtl/alsu_cmd_fifo.sv
// Command FIFO for the ALSU issuer: registered storage, head always visible on dout,
// DEPTH-wrapping binary pointers with a separate occupancy count.
module alsu_cmd_fifo
  import alsu_cmd_issuer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      flush,
  input  logic      push,
  input  logic      pop,
  input  alsu_cmd_t din,
  output alsu_cmd_t dout,
  output logic      full,
  empty
);

  localparam int              AW       = $clog2(DEPTH);
  localparam logic [AW-1:0]   PTR_ONE  = AW'(1);
  localparam logic [AW:0]     CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]     CNT_FULL = (AW+1)'(DEPTH);

  alsu_cmd_t     r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign full   = (r_count == CNT_FULL);
  assign empty  = (r_count == '0);
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign dout   = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      if (w_push && !w_pop)      r_count <= r_count + CNT_ONE;
      else if (w_pop && !w_push) r_count <= r_count - CNT_ONE;
    end
  end

  // Storage is data only; stale entries are harmless once the pointers reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

endmodule

// File: rtl/alsu_cmd_issuer.sv
// ALSU command issuer: FIFO-buffered commands driven onto registered ALSU pins, with
// SHIFT/ROTATE repeat. Optional invalid-command filter under ALSU_CMD_FILTER_EN.
module alsu_cmd_issuer
  import alsu_cmd_issuer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int RPT_W = CMD_RPT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  alsu_cmd_t         cmd,
  output logic signed [2:0] A,
  output logic signed [2:0] B,
  output logic              cin,
  output logic              serial_in,
  output logic              red_op_A,
  output logic              red_op_B,
  output logic              bypass_A,
  output logic              bypass_B,
  output logic              direction,
  output opcode_e           opcode,
  output logic              issue_valid,
  output logic              busy,
  output logic [15:0]       issued_cnt
`ifdef ALSU_CMD_FILTER_EN
  ,
  output logic [15:0]       dropped_cnt
`endif
);

  localparam logic [RPT_W-1:0] REM_ONE = RPT_W'(1);

  issuer_state_e    r_state;
  logic [RPT_W-1:0] r_rem;
  alsu_pins_t       r_pins;
  logic             r_issue_valid;
  logic [15:0]      r_issued_cnt;

  alsu_cmd_t w_head;
  alsu_cmd_t w_load;
  logic      w_load_vld;
  logic      w_full;
  logic      w_empty;
  logic      w_hold;
  logic      w_pop;
  logic      w_drop;

  alsu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (cmd_valid),
    .pop   (w_pop),
    .din   (cmd),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty)
  );

  assign cmd_ready = !w_full;
  assign busy      = !w_empty || (r_rem != '0);

  // A repeat in flight holds the pins; otherwise the head (if any) is popped this edge.
  always_comb begin
    w_hold     = (r_state != IDLE) && (r_rem != '0);
    w_pop      = 1'b0;
    w_drop     = 1'b0;
    w_load     = IDLE_CMD;
    w_load_vld = 1'b0;
    if (!w_hold && !w_empty) begin
      w_pop = 1'b1;
`ifdef ALSU_CMD_FILTER_EN
      w_drop = is_invalid_cmd(w_head);
`endif
      if (!w_drop) begin
        w_load     = w_head;
        w_load_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_rem         <= '0;
      r_pins        <= to_pins(IDLE_CMD);
      r_issue_valid <= 1'b0;
      r_issued_cnt  <= '0;
    end else if (flush) begin
      r_state       <= IDLE;
      r_rem         <= '0;
      r_pins        <= to_pins(IDLE_CMD);
      r_issue_valid <= 1'b0;
    end else if (w_hold) begin
      r_state       <= REPEAT;
      r_rem         <= r_rem - REM_ONE;
      r_issue_valid <= 1'b1;
      r_issued_cnt  <= r_issued_cnt + 16'd1;
    end else begin
      r_pins        <= to_pins(w_load);
      r_issue_valid <= w_load_vld;
      r_rem         <= is_repeat_op(w_load.opcode) ? w_load.rpt : '0;
      r_state       <= w_load_vld ? ISSUE : IDLE;
      if (w_load_vld) r_issued_cnt <= r_issued_cnt + 16'd1;
    end
  end

`ifdef ALSU_CMD_FILTER_EN
  logic [15:0] r_dropped_cnt;

  always_ff @(posedge clk) begin
    if (rst)                 r_dropped_cnt <= '0;
    else if (!flush && w_drop) r_dropped_cnt <= r_dropped_cnt + 16'd1;
  end

  assign dropped_cnt = r_dropped_cnt;
`endif

  assign opcode      = r_pins.opcode;
  assign A           = r_pins.A;
  assign B           = r_pins.B;
  assign cin         = r_pins.cin;
  assign serial_in   = r_pins.serial_in;
  assign red_op_A    = r_pins.red_op_A;
  assign red_op_B    = r_pins.red_op_B;
  assign bypass_A    = r_pins.bypass_A;
  assign bypass_B    = r_pins.bypass_B;
  assign direction   = r_pins.direction;
  assign issue_valid = r_issue_valid;
  assign issued_cnt  = r_issued_cnt;

endmodule

// File: tb/tb_alsu_cmd_issuer.sv
// Directed bench for alsu_cmd_issuer: vector table for single commands, hand sequences
// for repeat, full FIFO, flush, filter (ALSU_CMD_FILTER_EN) and reset.
module tb_alsu_cmd_issuer;
  import alsu_cmd_issuer_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              cmd_valid;
  logic              cmd_ready;
  alsu_cmd_t         cmd;
  logic signed [2:0] A;
  logic signed [2:0] B;
  logic              cin;
  logic              serial_in;
  logic              red_op_A;
  logic              red_op_B;
  logic              bypass_A;
  logic              bypass_B;
  logic              direction;
  opcode_e           opcode;
  logic              issue_valid;
  logic              busy;
  logic [15:0]       issued_cnt;
`ifdef ALSU_CMD_FILTER_EN
  logic [15:0]       dropped_cnt;
`endif

  int n_err = 0;
  int n_chk = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  alsu_cmd_issuer #(.DEPTH(4), .RPT_W(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd         (cmd),
    .A           (A),
    .B           (B),
    .cin         (cin),
    .serial_in   (serial_in),
    .red_op_A    (red_op_A),
    .red_op_B    (red_op_B),
    .bypass_A    (bypass_A),
    .bypass_B    (bypass_B),
    .direction   (direction),
    .opcode      (opcode),
    .issue_valid (issue_valid),
    .busy        (busy),
    .issued_cnt  (issued_cnt)
`ifdef ALSU_CMD_FILTER_EN
    ,
    .dropped_cnt (dropped_cnt)
`endif
  );

  typedef struct {
    alsu_cmd_t   cmd;
    logic [16:0] exp;   // {opcode, A, B, cin, serial_in, red_A, red_B, byp_A, byp_B, dir}
    int          n;     // issue cycles
  } vec_t;

  vec_t vecs [7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [16:0] pins_now();
    return {opcode, A, B, cin, serial_in, red_op_A, red_op_B, bypass_A, bypass_B, direction};
  endfunction

  function automatic logic [16:0] pins_of(input alsu_cmd_t c);
    return {c.opcode, c.A, c.B, c.cin, c.serial_in, c.red_op_A, c.red_op_B,
            c.bypass_A, c.bypass_B, c.direction};
  endfunction

  // ctl = {cin, serial_in, red_op_A, red_op_B, bypass_A, bypass_B, direction}
  function automatic alsu_cmd_t mk(input opcode_e op, input logic [2:0] a, input logic [2:0] b,
                                   input logic [6:0] ctl, input logic [2:0] rpt);
    alsu_cmd_t m;
    m.opcode    = op;
    m.A         = a;
    m.B         = b;
    m.cin       = ctl[6];
    m.serial_in = ctl[5];
    m.red_op_A  = ctl[4];
    m.red_op_B  = ctl[3];
    m.bypass_A  = ctl[2];
    m.bypass_B  = ctl[1];
    m.direction = ctl[0];
    m.rpt       = rpt;
    return m;
  endfunction

  task automatic exp_issue(input string nm, input logic [16:0] p);
    chk({nm, ".pins"}, 32'(pins_now()), 32'(p));
    chk({nm, ".valid"}, 32'(issue_valid), 32'd1);
  endtask

  task automatic exp_idle(input string nm);
    chk({nm, ".pins"}, 32'(pins_now()), 32'd0);
    chk({nm, ".valid"}, 32'(issue_valid), 32'd0);
  endtask

  alsu_cmd_t c_rot, c_shf, c_xor, c_x;
  alsu_cmd_t q [5];

  initial begin
    vecs[0] = '{mk(ADD,    3'd3, 3'b110, 7'b1000000, 3'd0), {3'd2, 3'b011, 3'b110, 7'b1000000}, 1};
    vecs[1] = '{mk(XOR,    3'd1, 3'd2,   7'b0000000, 3'd0), {3'd1, 3'b001, 3'b010, 7'b0000000}, 1};
    vecs[2] = '{mk(MULT,   3'b100, 3'd3, 7'b0000010, 3'd0), {3'd3, 3'b100, 3'b011, 7'b0000010}, 1};
    vecs[3] = '{mk(OR,     3'b111, 3'b111, 7'b0010000, 3'd0), {3'd0, 3'b111, 3'b111, 7'b0010000}, 1};
    vecs[4] = '{mk(SHIFT,  3'd2, 3'd0,   7'b0100001, 3'd2), {3'd4, 3'b010, 3'b000, 7'b0100001}, 3};
    vecs[5] = '{mk(ADD,    3'd1, 3'd1,   7'b0000000, 3'd5), {3'd2, 3'b001, 3'b001, 7'b0000000}, 1};
    vecs[6] = '{mk(ROTATE, 3'b101, 3'd0, 7'b0000100, 3'd0), {3'd5, 3'b101, 3'b000, 7'b0000100}, 1};

    // Reset with cmd_valid held high
    rst = 1'b1; flush = 1'b0; cmd_valid = 1'b1;
    cmd = mk(ADD, 3'd3, 3'd1, 7'b0, 3'd0);
    tick();
    tick();
    exp_idle("reset");
    chk("reset.cnt", 32'(issued_cnt), 32'd0);
    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.ready", 32'(cmd_ready), 32'd1);
`ifdef ALSU_CMD_FILTER_EN
    chk("reset.dropped", 32'(dropped_cnt), 32'd0);
`endif
    rst = 1'b0; cmd_valid = 1'b0;
    tick();
    exp_idle("post_reset");
    chk("post_reset.busy", 32'(busy), 32'd0);

    // Single commands: push at edge k, issue from edge k+1
    for (int i = 0; i < 7; i++) begin
      cmd = vecs[i].cmd; cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      chk($sformatf("vec%0d.latency_valid", i), 32'(issue_valid), 32'd0);
      chk($sformatf("vec%0d.busy", i), 32'(busy), 32'd1);
      for (int c = 0; c < vecs[i].n; c++) begin
        tick();
        exp_issue($sformatf("vec%0d.issue%0d", i, c), vecs[i].exp);
      end
      exp_cnt += vecs[i].n;
      tick();
      exp_idle($sformatf("vec%0d.after", i));
      chk($sformatf("vec%0d.cnt", i), 32'(issued_cnt), 32'(exp_cnt));
    end

    // SHIFT rpt=3 then XOR back-to-back
    c_shf = mk(SHIFT, 3'd1, 3'd0, 7'b0100001, 3'd3);
    c_xor = mk(XOR, 3'd1, 3'd2, 7'b0, 3'd0);
    cmd = c_shf; cmd_valid = 1'b1;
    tick();
    cmd = c_xor;
    tick();
    cmd_valid = 1'b0;
    exp_issue("rpt.shift0", pins_of(c_shf));
    for (int i = 1; i < 4; i++) begin
      tick();
      exp_issue($sformatf("rpt.shift%0d", i), pins_of(c_shf));
    end
    tick();
    exp_issue("rpt.xor", pins_of(c_xor));
    tick();
    exp_idle("rpt.after");
    exp_cnt += 5;
    chk("rpt.cnt", 32'(issued_cnt), 32'(exp_cnt));

    // Fill the FIFO behind ROTATE rpt=7, then drain in order
    c_rot = mk(ROTATE, 3'd3, 3'd0, 7'b0000001, 3'd7);
    q[0] = mk(ADD,  3'd1, 3'd0, 7'b0, 3'd0);
    q[1] = mk(ADD,  3'd2, 3'd0, 7'b1000000, 3'd0);
    q[2] = mk(XOR,  3'd3, 3'd1, 7'b0, 3'd0);
    q[3] = mk(OR,   3'd0, 3'd1, 7'b0000010, 3'd0);
    q[4] = mk(MULT, 3'd2, 3'd2, 7'b0, 3'd0);
    cmd = c_rot; cmd_valid = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) chk("full.ready_at3", 32'(cmd_ready), 32'd1);
      cmd = q[i];
      tick();
      exp_issue($sformatf("full.rot%0d", i), pins_of(c_rot));
    end
    cmd_valid = 1'b0;
    chk("full.ready_low", 32'(cmd_ready), 32'd0);
    chk("full.busy", 32'(busy), 32'd1);
    for (int i = 4; i < 8; i++) begin
      tick();
      exp_issue($sformatf("full.rot%0d", i), pins_of(c_rot));
    end
    tick();
    exp_issue("full.drain0", pins_of(q[0]));
    chk("full.ready_after_pop", 32'(cmd_ready), 32'd1);
    cmd = q[4]; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    exp_issue("full.drain1", pins_of(q[1]));
    chk("full.ready_pushpop", 32'(cmd_ready), 32'd1);
    for (int i = 2; i < 5; i++) begin
      tick();
      exp_issue($sformatf("full.drain%0d", i), pins_of(q[i]));
    end
    tick();
    exp_idle("full.after");
    chk("full.busy_after", 32'(busy), 32'd0);
    exp_cnt += 8 + 5;
    chk("full.cnt", 32'(issued_cnt), 32'(exp_cnt));

    // Flush in the middle of a repeat with two queued
    c_shf = mk(SHIFT, 3'd2, 3'd0, 7'b0100000, 3'd5);
    cmd = c_shf; cmd_valid = 1'b1;
    tick();
    cmd = q[0];
    tick();
    exp_issue("flush.pre0", pins_of(c_shf));
    cmd = q[1];
    tick();
    exp_issue("flush.pre1", pins_of(c_shf));
    c_x = mk(MULT, 3'd1, 3'd1, 7'b0, 3'd0);
    cmd = c_x; flush = 1'b1;
    tick();
    flush = 1'b0; cmd_valid = 1'b0;
    exp_idle("flush.now");
    chk("flush.busy", 32'(busy), 32'd0);
    chk("flush.ready", 32'(cmd_ready), 32'd1);
    exp_cnt += 2;
    chk("flush.cnt_kept", 32'(issued_cnt), 32'(exp_cnt));
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("flush.quiet%0d", i), 32'(issue_valid), 32'd0);
    end
    chk("flush.cnt_after", 32'(issued_cnt), 32'(exp_cnt));

    // Filter: MULT with reduction, INVALID_1, OR with reduction
    q[0] = mk(MULT,      3'd1, 3'd2, 7'b0010000, 3'd0);
    q[1] = mk(INVALID_1, 3'd1, 3'd1, 7'b0, 3'd0);
    q[2] = mk(OR,        3'd2, 3'd3, 7'b0001000, 3'd0);
    cmd = q[0]; cmd_valid = 1'b1;
    tick();
    cmd = q[1];
    tick();
`ifdef ALSU_CMD_FILTER_EN
    exp_idle("filt.mult");
`else
    exp_issue("filt.mult", pins_of(q[0]));
`endif
    cmd = q[2];
    tick();
    cmd_valid = 1'b0;
`ifdef ALSU_CMD_FILTER_EN
    exp_idle("filt.inv");
`else
    exp_issue("filt.inv", pins_of(q[1]));
`endif
    tick();
    exp_issue("filt.or", pins_of(q[2]));
    tick();
    exp_idle("filt.after");
`ifdef ALSU_CMD_FILTER_EN
    exp_cnt += 1;
    chk("filt.dropped", 32'(dropped_cnt), 32'd2);
`else
    exp_cnt += 3;
`endif
    chk("filt.cnt", 32'(issued_cnt), 32'(exp_cnt));

    // Reset while a repeat is in progress
    cmd = mk(ROTATE, 3'd1, 3'd0, 7'b0, 3'd3); cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("rst2.valid_pre", 32'(issue_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_idle("rst2");
    chk("rst2.cnt", 32'(issued_cnt), 32'd0);
    chk("rst2.busy", 32'(busy), 32'd0);
`ifdef ALSU_CMD_FILTER_EN
    chk("rst2.dropped", 32'(dropped_cnt), 32'd0);
`endif
    tick();
    chk("rst2.quiet", 32'(issue_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
